// File: rtl/calc_pkg.sv
// Shared calculator definitions: key scanner FSM states, the 4-bit key
// code shared with the display path, key-code constants and key helpers.
package calc_pkg;

    // Key index as produced by the scanner: row*4 + col.
    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        KP_SCAN,
        KP_DEBOUNCE,
        KP_PRESSED,
        KP_RELEASE
    } kp_state_t;

    // Keypad layout (row, col):
    //   r0: 1 2 3 +   r1: 4 5 6 -   r2: 7 8 9 *   r3: C 0 = /
    localparam key_code_t KEY_PLUS  = 4'd3;
    localparam key_code_t KEY_MINUS = 4'd7;
    localparam key_code_t KEY_MUL   = 4'd11;
    localparam key_code_t KEY_CLR   = 4'd12;
    localparam key_code_t KEY_EQ    = 4'd14;
    localparam key_code_t KEY_DIV   = 4'd15;
    localparam logic [3:0] NOT_DIGIT = 4'hF;

    // Digit value of a key index, NOT_DIGIT for operator keys.
    function automatic logic [3:0] key_to_digit(input key_code_t k);
        logic [3:0] d;
        unique case (k)
            4'd0:    d = 4'd1;
            4'd1:    d = 4'd2;
            4'd2:    d = 4'd3;
            4'd4:    d = 4'd4;
            4'd5:    d = 4'd5;
            4'd6:    d = 4'd6;
            4'd8:    d = 4'd7;
            4'd9:    d = 4'd8;
            4'd10:   d = 4'd9;
            4'd13:   d = 4'd0;
            default: d = NOT_DIGIT;
        endcase
        return d;
    endfunction

    // Lowest set row wins when several rows are closed.
    function automatic logic [1:0] kp_low_row(input logic [3:0] r);
        logic [1:0] idx;
        priority case (1'b1)
            r[0]:    idx = 2'd0;
            r[1]:    idx = 2'd1;
            r[2]:    idx = 2'd2;
            r[3]:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Index of the driven column (column drive is one-hot).
    function automatic logic [1:0] kp_col_idx(input logic [3:0] c);
        logic [1:0] idx;
        unique case (1'b1)
            c[1]:    idx = 2'd1;
            c[2]:    idx = 2'd2;
            c[3]:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchroniser for the asynchronous 4-bit row sense lines.
// Ports: clock, reset (sync, active-high), d_i raw rows, q_o synchronised rows.
module sync2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, debounce, key encode, one-entry
// valid/ready hold buffer with sticky overrun. Optional auto-repeat when
// KEYPAD_REPEAT_EN is defined.
// Ports: clock, reset (sync, active-high), row_in raw rows, col_out one-hot
// column drive, key_code/key_valid/key_ready handshake, overrun sticky flag.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int REPEAT_CYCLES   = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun
);

    if (SCAN_CYCLES < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("keypad_scanner: illegal cycle parameter");
    end

    // One counter serves scan timing and both debounce phases.
    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] row_s;
    kp_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_cap_q, row_cap_d;
    key_code_t  code_q, code_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       emit;
    logic       rep_fire;
    key_code_t  emit_code;

    sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (row_in),
        .q_o   (row_s)
    );

    assign emit_code = {kp_low_row(row_cap_q), kp_col_idx(col_q)};

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;

    // Runs only while the captured rows are still held; any exit from
    // PRESSED (row_s == 0) clears it.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == KP_PRESSED && row_s != '0) begin
            if (row_s == row_cap_q) begin
                if (rep_q == REP_LAST) begin
                    rep_fire = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end else begin
                rep_d = rep_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_cap_d = row_cap_q;
        emit      = rep_fire;
        unique case (state_q)
            KP_SCAN: begin
                if (row_s != '0) begin
                    row_cap_d = row_s;
                    cnt_d     = '0;
                    state_d   = KP_DEBOUNCE;
                end else if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    col_d = {col_q[2:0], col_q[3]};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KP_DEBOUNCE: begin
                if (row_s != row_cap_q) begin
                    cnt_d   = '0;
                    state_d = KP_SCAN;
                end else if (cnt_q == DB_LAST) begin
                    emit    = 1'b1;
                    cnt_d   = '0;
                    state_d = KP_PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KP_PRESSED: begin
                if (row_s == '0) begin
                    cnt_d   = '0;
                    state_d = KP_RELEASE;
                end
            end
            KP_RELEASE: begin
                if (row_s != '0) begin
                    cnt_d   = '0;
                    state_d = KP_PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    col_d   = {col_q[2:0], col_q[3]};
                    state_d = KP_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = KP_SCAN;
        endcase
    end

    // A same-cycle acceptance frees the slot, so the new key loads
    // instead of being counted as an overrun.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (emit && (!valid_q || key_ready)) begin
            code_d  = emit_code;
            valid_d = 1'b1;
        end else if (emit) begin
            ovr_d = 1'b1;
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= KP_SCAN;
            cnt_q     <= '0;
            col_q     <= 4'b0001;
            row_cap_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_cap_q <= row_cap_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign col_out   = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random
// presses, with a key scoreboard and handshake stability monitor.
module tb_keypad_scanner;

    localparam int SC  = 2;
    localparam int DB  = 4;
    localparam int REP = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in = 4'b0000;
    logic       key_ready = 1'b0;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    bit rand_ready = 1'b0;
    int exp_q[$];
    bit prev_hold = 1'b0;
    logic [3:0] prev_code = 4'b0000;

    keypad_scanner #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            if (rand_ready) key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << c);
    endfunction

    function automatic int low_row(input logic [3:0] m);
        int r = 0;
        for (int i = 3; i >= 0; i--) if (m[i]) r = i;
        return r;
    endfunction

    // Scoreboard and hold-stability monitor, sampled after input drive.
    always @(negedge clock) begin
        int exp_code;
        #1;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(key_valid), 32'd1);
                chk("hold_code", 32'(key_code), 32'(prev_code));
            end
            if (key_valid && key_ready) begin
                exp_code = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h10;
                chk("accept_code", 32'(key_code), exp_code);
                n_acc++;
            end
            prev_hold = key_valid && !key_ready;
            prev_code = key_code;
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        row_in = '0;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Return in the first cycle of the column before c, so a row driven
    // now is captured while column c is driven.
    task automatic arm(input int c);
        logic [3:0] p;
        logic [3:0] old;
        bit found;
        p = onehot((c + 3) % 4);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            old = col_out;
            tick();
            found = (col_out == p) && (old != p);
        end
        if (!found) chk("arm_found", 32'(found), 32'd1);
    endtask

    task automatic press_hold(input logic [3:0] mask, input int c, input int h);
        arm(c);
        row_in = mask;
        tick(h);
        row_in = '0;
        tick(DB + 4);
    endtask

    // Press with key_ready held high; checks per-cycle valid and column.
    task automatic press_ready(input logic [3:0] mask, input int c, input int h);
        int nrep, code, acc0, d;
        bit ev;
        code = low_row(mask) * 4 + c;
`ifdef KEYPAD_REPEAT_EN
        nrep = (h - 1 - DB) / REP;
`else
        nrep = 0;
`endif
        for (int m = 0; m <= nrep; m++) exp_q.push_back(code);
        acc0 = n_acc;
        key_ready = 1'b1;
        arm(c);
        row_in = mask;
        for (int k = 1; k <= h + 3 + DB; k++) begin
            tick();
            d  = k - 3 - DB;
            ev = (d >= 0) && (d % REP == 0) && (d / REP <= nrep);
            chk("press_valid", 32'(key_valid), 32'(ev));
            if (k >= 2)
                chk("press_col", 32'(col_out),
                    32'(onehot((k <= h + 2 + DB) ? c : (c + 1) % 4)));
            if (k == h) row_in = '0;
        end
        chk("press_count", n_acc - acc0, nrep + 1);
    endtask

    initial begin
        int g, c, h;
        logic [3:0] mask;

        tick(3);
        reset = 1'b0;
        chk("rst_col", 32'(col_out), 32'd1);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);

        // Clean press: key 9 (row 2, column 1).
        press_ready(4'b0100, 1, 20);
        chk("clean_drain", exp_q.size(), 0);

        // Glitches no longer than the debounce window.
        key_ready = 1'b0;
        for (int it = 0; it < 8; it++) begin
            g = $urandom_range(1, DB);
            c = $urandom_range(0, 3);
            arm(c);
            row_in = onehot($urandom_range(0, 3));
            for (int k = 1; k <= g + 3 + SC; k++) begin
                tick();
                if (k == g) row_in = '0;
                chk("glitch_valid", 32'(key_valid), 32'd0);
                if (k >= 2)
                    chk("glitch_col", 32'(col_out),
                        32'(onehot((k < g + 3 + SC) ? c : (c + 1) % 4)));
            end
        end
        chk("glitch_ovr", 32'(overrun), 32'd0);

        // Back-pressure: key 0 held, key 5 dropped.
        do_reset();
        key_ready = 1'b0;
        exp_q.push_back(0);
        press_hold(4'b0001, 0, 12);
        chk("bp_valid1", 32'(key_valid), 32'd1);
        chk("bp_code1", 32'(key_code), 32'd0);
        chk("bp_ovr1", 32'(overrun), 32'd0);
        press_hold(4'b0010, 1, 12);
        chk("bp_valid2", 32'(key_valid), 32'd1);
        chk("bp_code2", 32'(key_code), 32'd0);
        chk("bp_ovr2", 32'(overrun), 32'd1);
        key_ready = 1'b1;
        tick();
        chk("bp_valid3", 32'(key_valid), 32'd0);
        chk("bp_ovr3", 32'(overrun), 32'd1);
        chk("bp_drain", exp_q.size(), 0);

        // Accept of key 3 in the same cycle key 7 is emitted.
        do_reset();
        key_ready = 1'b0;
        exp_q.push_back(3);
        press_hold(4'b0001, 3, 12);
        chk("sim_code1", 32'(key_code), 32'd3);
        chk("sim_valid1", 32'(key_valid), 32'd1);
        exp_q.push_back(7);
        arm(3);
        row_in = 4'b0010;
        tick(DB + 2);
        key_ready = 1'b1;
        tick();
        chk("sim_code2", 32'(key_code), 32'd7);
        chk("sim_valid2", 32'(key_valid), 32'd1);
        chk("sim_ovr", 32'(overrun), 32'd0);
        tick(12 - DB - 3);
        row_in = '0;
        tick(DB + 4);
        chk("sim_valid3", 32'(key_valid), 32'd0);
        chk("sim_drain", exp_q.size(), 0);

        // Reset two clocks into debounce.
        do_reset();
        key_ready = 1'b0;
        arm(2);
        row_in = 4'b1000;
        tick(5);
        reset  = 1'b1;
        row_in = '0;
        tick();
        reset = 1'b0;
        chk("rmd_col", 32'(col_out), 32'd1);
        chk("rmd_valid", 32'(key_valid), 32'd0);
        chk("rmd_ovr", 32'(overrun), 32'd0);
        tick();
        chk("rmd_col2", 32'(col_out), 32'd1);
        tick();
        chk("rmd_col3", 32'(col_out), 32'd2);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("rmd_none", 32'(key_valid), 32'd0);
        end

        // Long hold of key 12: one emission, or repeats with the macro.
        do_reset();
        press_ready(4'b1000, 0, 40);
        chk("rep_drain", exp_q.size(), 0);

        // Random presses (multi-row masks) with a random consumer.
        do_reset();
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            mask = 4'($urandom_range(1, 15));
            c    = $urandom_range(0, 3);
            h    = $urandom_range(DB + 1, DB + REP);
            exp_q.push_back(low_row(mask) * 4 + c);
            press_hold(mask, c, h);
            for (int i = 0; i < 200 && key_valid; i++) tick();
            if (key_valid) chk("rnd_drain", 32'(key_valid), 32'd0);
        end
        rand_ready = 1'b0;
        key_ready  = 1'b0;
        tick();
        chk("rnd_ovr", 32'(overrun), 32'd0);
        chk("rnd_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
